// File: rtl/rv32i_fetch_pkg.sv
// Shared types for the RV32I fetch stage: NOP encoding and the buffered fetch entry.
package rv32i_package;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Response buffer for the fetch stage: sync FIFO of fetch entries.
// Clear wins over push and pop.
module rv32i_fetch_fifo
  import rv32i_package::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t pop_data,
  input  logic         clear,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_push  = push && !clear;
  assign do_pop   = pop && !clear && (count != '0);
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap on their own
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(do_push && !do_pop && (count == CW'(DEPTH))));
endmodule

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: credit-limited imem requests, in-order response buffer,
// one instruction per cycle to decode. `RV32I_FETCH_PERF_EN adds perf counters.
module rv32i_fetch
  import rv32i_package::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        decode_stall,
  input  logic        decode_flush,
  output logic [31:0] fetch_instruction,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid
`ifdef RV32I_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q, rsp_pc_q, target;
  logic [CW-1:0] outstanding, outstanding_next, drop_cnt, fifo_count;
  logic [CW:0]   credits_used;
  logic          accept, keep, out_load, fifo_empty, bypass, push, pop;
  logic          load_valid, load_nop;
  fetch_entry_t  fifo_head;

  // Every in-flight request owns a FIFO slot, so the buffer cannot overflow
  assign credits_used     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid   = reset && !redirect_valid && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr    = pc_q;
  assign accept           = imem_req_valid && imem_req_ready;
  assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);
  assign target           = {redirect_pc[31:2], 2'b00};

  assign keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign out_load   = !redirect_valid && !decode_flush && !decode_stall;
  assign fifo_empty = (fifo_count == '0);
  assign bypass     = out_load && fifo_empty && keep;
  assign push       = keep && !bypass;
  assign pop        = out_load && !fifo_empty;
  assign load_valid = pop || bypass;
  assign load_nop   = redirect_valid || decode_flush || (out_load && !load_valid);

  rv32i_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{pc: rsp_pc_q, instr: imem_rsp_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .clear     (redirect_valid),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the wrong path
        pc_q     <= target;
        rsp_pc_q <= target;
        drop_cnt <= outstanding_next;
      end else begin
        if (accept) pc_q <= pc_q + 32'd4;
        if (keep)   rsp_pc_q <= rsp_pc_q + 32'd4;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_instruction <= NOP_INSTR;
      fetch_pc          <= RESET_PC;
      fetch_valid       <= 1'b0;
    end else if (load_nop) begin
      fetch_instruction <= NOP_INSTR;
      fetch_valid       <= 1'b0;
    end else if (pop) begin
      fetch_instruction <= fifo_head.instr;
      fetch_pc          <= fifo_head.pc;
      fetch_valid       <= 1'b1;
    end else if (bypass) begin
      fetch_instruction <= imem_rsp_data;
      fetch_pc          <= rsp_pc_q;
      fetch_valid       <= 1'b1;
    end
  end

`ifdef RV32I_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (load_valid) perf_fetched <= perf_fetched + 32'd1;
      if (load_nop)   perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: in-order imem responder plus an expected-fetch scoreboard.
module tb_rv32i_fetch;
  import rv32i_package::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0, reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        decode_stall = 1'b0, decode_flush = 1'b0;
  logic [31:0] fetch_instruction, fetch_pc;
  logic        fetch_valid;
`ifdef RV32I_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  always #5 clk = ~clk;

  rv32i_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .decode_stall      (decode_stall),
    .decode_flush      (decode_flush),
`ifdef RV32I_FETCH_PERF_EN
    .perf_fetched      (perf_fetched),
    .perf_bubbles      (perf_bubbles),
`endif
    .fetch_instruction (fetch_instruction),
    .fetch_pc          (fetch_pc),
    .fetch_valid       (fetch_valid)
  );

  int           total = 0, bad = 0;
  fetch_entry_t sb[$];
  logic [31:0]  pend[$];
  logic [31:0]  exp_pc = RST_PC;
  logic         rsp_hold = 1'b0;
  logic         obs_req;
  fetch_entry_t held;
  logic         held_valid = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h00A0_0093 + (a << 5);
  endfunction

  // One clock: imem responds one cycle after accept; outputs checked #1 after the edge
  task automatic step();
    logic acc, hold_chk, redir;
    fetch_entry_t e;
    imem_rsp_valid = (pend.size() > 0) && !rsp_hold;
    imem_rsp_data  = imem_rsp_valid ? word_at(pend[0]) : 32'h0;
    @(negedge clk);
    obs_req = imem_req_valid;
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      total++;
      if (imem_req_addr !== exp_pc) begin
        bad++; $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_pc);
      end
      pend.push_back(imem_req_addr);
      sb.push_back('{pc: exp_pc, instr: word_at(exp_pc)});
      exp_pc += 32'd4;
    end
    hold_chk = decode_stall && !redirect_valid && !decode_flush;
    redir    = redirect_valid;
    @(posedge clk); #1;
    if (imem_rsp_valid) pend.delete(0);
    if (redir) begin
      sb.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    total++;
    if (hold_chk) begin
      if ({fetch_valid, fetch_pc, fetch_instruction} !== {held_valid, held.pc, held.instr}) begin
        bad++; $display("FAIL stall_hold: got v=%0b pc=%h i=%h want v=%0b pc=%h i=%h",
                        fetch_valid, fetch_pc, fetch_instruction, held_valid, held.pc, held.instr);
      end
    end else if (fetch_valid) begin
      if (sb.size() == 0) begin
        bad++; $display("FAIL unexpected_fetch: got pc=%h want no valid fetch", fetch_pc);
      end else begin
        e = sb.pop_front();
        if (fetch_pc !== e.pc || fetch_instruction !== e.instr) begin
          bad++; $display("FAIL fetch_order: got pc=%h i=%h want pc=%h i=%h",
                          fetch_pc, fetch_instruction, e.pc, e.instr);
        end
      end
    end else if (fetch_instruction !== NOP_INSTR) begin
      bad++; $display("FAIL bubble_nop: got %h want %h", fetch_instruction, NOP_INSTR);
    end
    held = '{pc: fetch_pc, instr: fetch_instruction};
    held_valid = fetch_valid;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 4;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
    if (fetch_pc !== RST_PC) begin bad++; $display("FAIL rst_pc: got %h want %h", fetch_pc, RST_PC); end
    if (fetch_instruction !== NOP_INSTR) begin
      bad++; $display("FAIL rst_instr: got %h want %h", fetch_instruction, NOP_INSTR);
    end
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    imem_req_ready = 1'b1;
    step(); step();
    total++;
    if (fetch_valid !== 1'b1 || fetch_pc !== RST_PC || fetch_instruction !== 32'h00A0_0093) begin
      bad++; $display("FAIL first_fetch: got v=%0b pc=%h i=%h want v=1 pc=%h i=00a00093",
                      fetch_valid, fetch_pc, fetch_instruction, RST_PC);
    end
    repeat (8) begin
      step();
      total++;
      if (fetch_valid !== 1'b1) begin bad++; $display("FAIL stream_valid: got %b want 1", fetch_valid); end
    end
  endtask

  task automatic test_imem_backpressure();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (obs_req !== 1'b1) begin bad++; $display("FAIL req_pending: got %b want 1", obs_req); end
      if (i >= 1) begin
        total++;
        if (fetch_valid !== 1'b0 || fetch_instruction !== NOP_INSTR) begin
          bad++; $display("FAIL starve_bubble: got v=%0b i=%h want v=0 i=%h",
                          fetch_valid, fetch_instruction, NOP_INSTR);
        end
      end
    end
    imem_req_ready = 1'b1;
    step(); step();
    repeat (4) begin
      step();
      total++;
      if (fetch_valid !== 1'b1) begin bad++; $display("FAIL resume_valid: got %b want 1", fetch_valid); end
    end
  endtask

  task automatic test_decode_stall();
    decode_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i >= 1) begin
        total++;
        if (obs_req !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b want 0", obs_req); end
      end
    end
    decode_stall = 1'b0;
    repeat (6) begin
      step();
      total++;
      if (fetch_valid !== 1'b1) begin bad++; $display("FAIL release_valid: got %b want 1", fetch_valid); end
    end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    rsp_hold = 1'b1;
    step(); step();
    total++;
    if (obs_req !== 1'b0) begin bad++; $display("FAIL credit_limit: got %b want 0", obs_req); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    total += 2;
    if (obs_req !== 1'b0) begin bad++; $display("FAIL redirect_req: got %b want 0", obs_req); end
    if (fetch_valid !== 1'b0) begin bad++; $display("FAIL redirect_bubble: got %b want 0", fetch_valid); end
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (fetch_valid) found = 1'b1;
    end
    total++;
    if (!found || fetch_pc !== 32'h0000_0100) begin
      bad++; $display("FAIL redirect_target: got found=%0b pc=%h want found=1 pc=00000100", found, fetch_pc);
    end
  endtask

  task automatic test_back_to_back();
    bit found = 1'b0;
    rsp_hold = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    rsp_hold    = 1'b0;
    redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (fetch_valid) found = 1'b1;
    end
    total++;
    if (!found || fetch_pc !== 32'h0000_0300) begin
      bad++; $display("FAIL b2b_target: got found=%0b pc=%h want found=1 pc=00000300", found, fetch_pc);
    end
    repeat (4) begin
      step();
      total++;
      if (fetch_valid !== 1'b1) begin bad++; $display("FAIL b2b_stream: got %b want 1", fetch_valid); end
    end
  endtask

  task automatic test_reset_midstream();
    bit found = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    total += 4;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_req_valid: got %b want 0", imem_req_valid); end
    if (fetch_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", fetch_valid); end
    if (fetch_pc !== RST_PC) begin bad++; $display("FAIL mid_pc: got %h want %h", fetch_pc, RST_PC); end
    if (fetch_instruction !== NOP_INSTR) begin
      bad++; $display("FAIL mid_instr: got %h want %h", fetch_instruction, NOP_INSTR);
    end
`ifdef RV32I_FETCH_PERF_EN
    total++;
    if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0) begin
      bad++; $display("FAIL perf_reset: got f=%0d b=%0d want 0 0", perf_fetched, perf_bubbles);
    end
`endif
    pend.delete();
    sb.delete();
    exp_pc = RST_PC;
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (fetch_valid) found = 1'b1;
    end
    total++;
    if (!found || fetch_pc !== RST_PC || fetch_instruction !== word_at(RST_PC)) begin
      bad++; $display("FAIL restart_fetch: got found=%0b pc=%h i=%h want found=1 pc=%h i=%h",
                      found, fetch_pc, fetch_instruction, RST_PC, word_at(RST_PC));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_imem_backpressure();
    test_decode_stall();
    test_redirect();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
